sayeh_muldiv_unit: RTL and testbench

//  Iterative 16-bit unsigned multiply/divide unit downstream of the SAYEH register file.

---
 rtl/sayeh_muldiv_unit_if.sv | 16 +
 rtl/sayeh_muldiv_unit.sv | 109 ++++++++++
 tb/tb_sayeh_muldiv_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sayeh_muldiv_unit_if.sv
// Controller-facing bundle of the SAYEH multiply/divide unit:
// launch handshake, register-file operands and lo/hi result write-back.
interface sayeh_muldiv_unit_if #(parameter int WIDTH = 16);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;
    logic             div_zero;

    modport master (output start, op, a, b, input busy, done, res_lo, res_hi, div_zero);
    modport slave  (input start, op, a, b, output busy, done, res_lo, res_hi, div_zero);
endinterface

// File: rtl/sayeh_muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit for SAYEH.
// One iteration per cycle; results only update when an operation completes.
module sayeh_muldiv_unit #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    sayeh_muldiv_unit_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state;
    logic             op_q;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [CW-1:0]    count;
    logic             busy_q;
    logic             done_q;
    logic             dz_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shl;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;

    // acc_hi/acc_lo double as {product_hi, multiplier} or {remainder, quotient}
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shl  = {acc_hi, acc_lo[WIDTH-1]};
        div_ge   = div_shl >= {1'b0, opnd};
        div_diff = div_shl[WIDTH-1:0] - opnd;
        if (op_q) begin
            nxt_hi = div_ge ? div_diff : div_shl[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= 1'b0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            count  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            lo_q   <= '0;
            hi_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q <= bus.op;
                        dz_q <= bus.op && (bus.b == '0);
                        if (bus.op && (bus.b == '0)) begin
                            lo_q   <= '1;
                            hi_q   <= bus.a;
                            done_q <= 1'b1;
                            state  <= FIN;
                        end else begin
                            opnd   <= bus.op ? bus.b : bus.a;
                            acc_hi <= '0;
                            acc_lo <= bus.op ? bus.a : bus.b;
                            count  <= '0;
                            busy_q <= 1'b1;
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    count  <= count + CW'(1);
                    // Final iteration publishes straight to the outputs so done lines up with FIN
                    if (count == CW'(WIDTH - 1)) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        lo_q   <= nxt_lo;
                        hi_q   <= nxt_hi;
                        state  <= FIN;
                    end
                end
                FIN: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.res_lo   = lo_q;
    assign bus.res_hi   = hi_q;
    assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_sayeh_muldiv_unit.sv
// Self-checking bench for sayeh_muldiv_unit: directed corner cases plus
// randomized operations compared against an arithmetic reference model.
module tb_sayeh_muldiv_unit;
    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] held;

    sayeh_muldiv_unit_if #(.WIDTH(W)) bus();
    sayeh_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {hi, lo} as the register file should see it after done
    function automatic logic [31:0] ref_model(input logic op, input logic [15:0] a, input logic [15:0] b);
        int unsigned ua;
        int unsigned ub;
        ua = a;
        ub = b;
        if (!op) return ua * ub;
        if (ub == 0) return {a, 16'hFFFF};
        return ((ua % ub) << 16) | (ua / ub);
    endfunction

    task automatic do_op(input string tag, input logic op, input logic [15:0] a,
                         input logic [15:0] b, input bit noise);
        logic [31:0] exp;
        bit          dz;
        int          k;
        int          nbusy;
        int          bad_hold;
        exp      = ref_model(op, a, b);
        dz       = op && (b == 0);
        k        = 1;
        nbusy    = 0;
        bad_hold = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0; bus.op = 1'($urandom); bus.a = 16'($urandom); bus.b = 16'($urandom);
        check({tag, "_dz_at_start"}, 32'(bus.div_zero), 32'(dz));
        while (!bus.done && k < 40) begin
            if (bus.busy) nbusy++;
            if ({bus.res_hi, bus.res_lo} !== held) bad_hold++;
            bus.start = noise && (k == 5);
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, 32'(k), dz ? 32'd1 : 32'd17);
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_busy_cycles"}, 32'(nbusy), dz ? 32'd0 : 32'd16);
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        check({tag, "_no_intermediate"}, 32'(bad_hold), 32'd0);
        check({tag, "_result"}, {bus.res_hi, bus.res_lo}, exp);
        check({tag, "_div_zero"}, 32'(bus.div_zero), 32'(dz));
        held = exp;
        for (int j = 0; j < 3; j++) begin
            bus.start = noise && (j == 0);
            bus.op = 1'($urandom); bus.a = 16'($urandom); bus.b = 16'($urandom);
            @(negedge clk);
            check({tag, "_hold_res"}, {bus.res_hi, bus.res_lo}, held);
            check({tag, "_hold_flags"}, {29'd0, bus.done, bus.busy, bus.div_zero}, {30'd0, 2'(dz)});
        end
        bus.start = 1'b0;
    endtask

    task automatic check_zeroed(input string tag);
        check({tag, "_res"}, {bus.res_hi, bus.res_lo}, 32'd0);
        check({tag, "_flags"}, {29'd0, bus.done, bus.busy, bus.div_zero}, 32'd0);
    endtask

    initial begin
        int ndone;
        logic       rop;
        logic [15:0] ra;
        logic [15:0] rb;

        rst = 1'b1;
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 16'd3; bus.b = 16'd5;
        repeat (2) @(negedge clk);
        check_zeroed("reset");
        rst = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check_zeroed("after_reset");
        held = 32'd0;

        do_op("mul_ffff", 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
        do_op("div_1000_7", 1'b1, 16'd1000, 16'd7, 1'b0);
        do_op("div_5_9", 1'b1, 16'd5, 16'd9, 1'b0);
        do_op("div_zero", 1'b1, 16'h1234, 16'd0, 1'b0);
        do_op("mul_noise", 1'b0, 16'd300, 16'd200, 1'b1);

        // Abort a divide mid-flight with reset
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b1; bus.a = 16'd50000; bus.b = 16'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        check("abort_busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zeroed("abort_reset");
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done || bus.busy) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        held = 32'd0;
        do_op("div_after_rst", 1'b1, 16'd50000, 16'd3, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rop = 1'($urandom);
            ra  = 16'($urandom);
            case ($urandom % 4)
                0:       rb = 16'd0;
                1:       rb = 16'($urandom_range(1, 15));
                default: rb = 16'($urandom);
            endcase
            do_op("rand", rop, ra, rb, ($urandom % 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
